// File: rtl/irq_pending_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : irq_pending_ctrl
// Purpose  : 8-channel pending-interrupt capture with a fixed-priority,
//            single-outstanding-grant arbiter (bit 7 highest priority).
//            Optional macro IRQ_OVERRUN_EN adds per-channel overrun flags (ovr).
// Revision : 1.0 - initial release
// ============================================================================
module irq_pending_ctrl #(
  parameter int EDGE_DET = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic [7:0] mask,
  input  logic       en,
  input  logic       irq_ack,
  output logic       irq_valid,
  output logic [2:0] irq_id,
  output logic [7:0] pending
`ifdef IRQ_OVERRUN_EN
  ,
  output logic [7:0] ovr
`endif
);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t     state_q;
  logic       irq_valid_q;
  logic [2:0] irq_id_q;
  logic [7:0] req_dly_q;
  logic [7:0] pending_q;
  logic [7:0] pending_d;
  logic [7:0] set_vec;
  logic [7:0] clr_vec;
  logic [7:0] eligible;
  logic [2:0] win_id;

  generate
    if (EDGE_DET != 0) begin : g_edge
      assign set_vec = req & ~req_dly_q;
    end else begin : g_level
      assign set_vec = req;
    end
  endgenerate

  always_comb begin
    clr_vec = 8'h00;
    if (state_q == BUSY && irq_ack) begin
      clr_vec[irq_id_q] = 1'b1;
    end
  end

  // A same-edge set re-arms the channel even while it is being acknowledged.
  assign pending_d = (pending_q & ~clr_vec) | set_vec;
  assign eligible  = pending_q & ~mask;

  always_comb begin
    win_id = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (eligible[i]) begin
        win_id = i[2:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      irq_valid_q <= 1'b0;
      irq_id_q    <= 3'd0;
      pending_q   <= 8'h00;
      req_dly_q   <= 8'h00;
    end else begin
      req_dly_q <= req;
      pending_q <= pending_d;
      case (state_q)
        IDLE: begin
          if (en && (eligible != 8'h00)) begin
            irq_id_q    <= win_id;
            irq_valid_q <= 1'b1;
            state_q     <= BUSY;
          end
        end
        BUSY: begin
          if (irq_ack) begin
            irq_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
      endcase
    end
  end

`ifdef IRQ_OVERRUN_EN
  logic [7:0] ovr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovr_q <= 8'h00;
    end else begin
      ovr_q <= (ovr_q & ~clr_vec) | (set_vec & pending_q & ~clr_vec);
    end
  end

  assign ovr = ovr_q;
`endif

  assign irq_valid = irq_valid_q;
  assign irq_id    = irq_id_q;
  assign pending   = pending_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_pending_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_pending_ctrl
// Purpose  : Self-checking bench for irq_pending_ctrl (EDGE_DET=1), with
//            overrun checks when IRQ_OVERRUN_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_pending_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic [7:0] mask = 8'h00;
  logic       en = 1'b0;
  logic       irq_ack = 1'b0;
  logic       irq_valid;
  logic [2:0] irq_id;
  logic [7:0] pending;
`ifdef IRQ_OVERRUN_EN
  logic [7:0] ovr;
`endif

  irq_pending_ctrl #(.EDGE_DET(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .mask      (mask),
    .en        (en),
    .irq_ack   (irq_ack),
    .irq_valid (irq_valid),
    .irq_id    (irq_id),
    .pending   (pending)
`ifdef IRQ_OVERRUN_EN
    ,
    .ovr       (ovr)
`endif
  );

  always #5 clk = ~clk;

  // One record = inputs applied for one cycle plus outputs expected after that edge.
  typedef struct packed {
    logic [7:0] req;
    logic [7:0] mask;
    logic       en;
    logic       ack;
    logic       valid;
    logic [2:0] id;
    logic [7:0] pend;
    logic [7:0] ovr;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  int   step_no = 0;
  vec_t sb[$];
  vec_t tbl[25];

  function automatic vec_t mk(input logic [7:0] r, input logic [7:0] m, input logic e,
                              input logic a, input logic v, input logic [2:0] id,
                              input logic [7:0] p, input logic [7:0] o);
    vec_t t;
    t.req = r; t.mask = m; t.en = e; t.ack = a;
    t.valid = v; t.id = id; t.pend = p; t.ovr = o;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input vec_t e);
    chk({tag, " irq_valid"}, {7'd0, irq_valid}, {7'd0, e.valid});
    chk({tag, " irq_id"},    {5'd0, irq_id},    {5'd0, e.id});
    chk({tag, " pending"},   pending,           e.pend);
`ifdef IRQ_OVERRUN_EN
    chk({tag, " ovr"},       ovr,               e.ovr);
`endif
  endtask

  task automatic step(input vec_t v);
    vec_t e;
    @(negedge clk);
    req = v.req; mask = v.mask; en = v.en; irq_ack = v.ack;
    sb.push_back(v);
    @(posedge clk);
    #1;
    step_no++;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL step%0d scoreboard: got empty want entry", step_no);
    end else begin
      e = sb.pop_front();
      check_outputs($sformatf("step%0d", step_no), e);
    end
  endtask

  initial begin
    //           req    mask  en    ack   vld   id    pend   ovr
    tbl[0]  = mk(8'h80, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h80, 8'h00);
    tbl[1]  = mk(8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 3'd7, 8'h80, 8'h00);
    tbl[2]  = mk(8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 3'd7, 8'h00, 8'h00);
    tbl[3]  = mk(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 3'd7, 8'h00, 8'h00);
    tbl[4]  = mk(8'h22, 8'h00, 1'b1, 1'b0, 1'b0, 3'd7, 8'h22, 8'h00);
    tbl[5]  = mk(8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 3'd5, 8'h22, 8'h00);
    tbl[6]  = mk(8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 3'd5, 8'h22, 8'h00);
    tbl[7]  = mk(8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 3'd5, 8'h02, 8'h00);
    tbl[8]  = mk(8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 3'd1, 8'h02, 8'h00);
    tbl[9]  = mk(8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 3'd1, 8'h00, 8'h00);
    tbl[10] = mk(8'h22, 8'h20, 1'b1, 1'b0, 1'b0, 3'd1, 8'h22, 8'h00);
    tbl[11] = mk(8'h00, 8'h20, 1'b1, 1'b0, 1'b1, 3'd1, 8'h22, 8'h00);
    tbl[12] = mk(8'h00, 8'h20, 1'b1, 1'b1, 1'b0, 3'd1, 8'h20, 8'h00);
    tbl[13] = mk(8'h00, 8'h20, 1'b1, 1'b0, 1'b0, 3'd1, 8'h20, 8'h00);
    tbl[14] = mk(8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 3'd5, 8'h20, 8'h00);
    tbl[15] = mk(8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 3'd5, 8'h00, 8'h00);
    tbl[16] = mk(8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 3'd5, 8'h00, 8'h00);
    tbl[17] = mk(8'h04, 8'h00, 1'b1, 1'b0, 1'b0, 3'd5, 8'h04, 8'h00);
    tbl[18] = mk(8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 3'd2, 8'h04, 8'h00);
    tbl[19] = mk(8'h10, 8'hFF, 1'b0, 1'b0, 1'b1, 3'd2, 8'h14, 8'h00);
    tbl[20] = mk(8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 3'd2, 8'h10, 8'h00);
    tbl[21] = mk(8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 3'd4, 8'h10, 8'h00);
    tbl[22] = mk(8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 3'd4, 8'h00, 8'h00);
    tbl[23] = mk(8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 3'd4, 8'h01, 8'h00);
    tbl[24] = mk(8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 3'd4, 8'h01, 8'h00);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs("reset", mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00));
    rst = 1'b0;

    for (int i = 0; i < 25; i++) begin
      step(tbl[i]);
    end

    // en held low with channel 0 pending: still no grant, then grant on enable.
    for (int i = 0; i < 8; i++) begin
      step(mk(8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 3'd4, 8'h01, 8'h00));
    end
    step(mk(8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 3'd0, 8'h01, 8'h00));
    step(mk(8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00));

    // Channel 3: overrun pulse before ack, then ack coinciding with a new edge.
    step(mk(8'h08, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h08, 8'h00));
    step(mk(8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 3'd3, 8'h08, 8'h00));
    step(mk(8'h08, 8'h00, 1'b1, 1'b0, 1'b1, 3'd3, 8'h08, 8'h08));
    step(mk(8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 3'd3, 8'h00, 8'h00));
    step(mk(8'h08, 8'h00, 1'b1, 1'b0, 1'b0, 3'd3, 8'h08, 8'h00));
    step(mk(8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 3'd3, 8'h08, 8'h00));
    step(mk(8'h08, 8'h00, 1'b1, 1'b1, 1'b0, 3'd3, 8'h08, 8'h00));
    step(mk(8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 3'd3, 8'h08, 8'h00));
    step(mk(8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 3'd3, 8'h00, 8'h00));

    // Reset while granting channel 6 must act without a clock edge.
    step(mk(8'h40, 8'h00, 1'b1, 1'b0, 1'b0, 3'd3, 8'h40, 8'h00));
    step(mk(8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 3'd6, 8'h40, 8'h00));
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_outputs("async_rst", mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(mk(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00));
    end
    step(mk(8'h40, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h40, 8'h00));
    step(mk(8'h40, 8'h00, 1'b1, 1'b0, 1'b1, 3'd6, 8'h40, 8'h00));
    step(mk(8'h40, 8'h00, 1'b1, 1'b1, 1'b0, 3'd6, 8'h00, 8'h00));

    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_drain: got %0d want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
